// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline stages.
//   - ADDR_WIDTH / DATA_WIDTH / REGISTER_INDEXING_WIDTH: fixed datapath widths
//   - op_flags_t: one-hot-ish opcode class bundle carried down the pipe
//   - funct3 load/store size encodings
//   - mem_state_t: memory stage controller states
//   - is_misaligned(): natural-alignment test for a load/store access
package pipeline_pkg;

  localparam int ADDR_WIDTH              = 32;
  localparam int DATA_WIDTH              = 32;
  localparam int REGISTER_INDEXING_WIDTH = $clog2(32);

  typedef struct packed {
    logic register_arith;
    logic immediate_arith;
    logic load;
    logic store;
    logic branch;
    logic immediate_jump;
    logic register_jump;
    logic load_upper;
    logic load_upper_pc;
    logic environment;
    logic opcode_legal;
  } op_flags_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    READY = 2'd3
  } mem_state_t;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (funct3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/memory_stage_mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
//   Inputs : funct3 (size/sign), addr_lo (byte offset), store_data, rdata
//   Outputs: wstrb (byte enables), wdata (store data replicated per size),
//            load_data (load value shifted down and sign/zero extended)
// The byte offset is reduced to the access's natural alignment, so a
// halfword only looks at addr_lo[1] and a word always uses lane 0.
module mem_lane_align
  import pipeline_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            wstrb,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [1:0]            offset;
  logic [DATA_WIDTH-1:0] shifted;

  function automatic logic [DATA_WIDTH-1:0] extend_byte(input logic [7:0] b,
                                                         input logic       sgn);
    logic signed [7:0]            b_s;
    logic signed [DATA_WIDTH-1:0] ext_s;
    b_s   = b;
    ext_s = b_s;
    return sgn ? ext_s : {{(DATA_WIDTH-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_half(input logic [15:0] h,
                                                         input logic        sgn);
    logic signed [15:0]           h_s;
    logic signed [DATA_WIDTH-1:0] ext_s;
    h_s   = h;
    ext_s = h_s;
    return sgn ? ext_s : {{(DATA_WIDTH-16){1'b0}}, h};
  endfunction

  always_comb begin
    offset = 2'b00;
    case (funct3[1:0])
      2'b00:   offset = addr_lo;
      2'b01:   offset = {addr_lo[1], 1'b0};
      default: offset = 2'b00;
    endcase
  end

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (funct3)
      LB:      load_data = extend_byte(shifted[7:0], 1'b1);
      LH:      load_data = extend_half(shifted[15:0], 1'b1);
      LBU:     load_data = extend_byte(shifted[7:0], 1'b0);
      LHU:     load_data = extend_half(shifted[15:0], 1'b0);
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
//   Upstream   : prev_done / stall_prev handshake, instruction bundle *_in
//   Downstream : done_next / next_stall handshake, instruction bundle *_out
//   Memory bus : mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata out,
//                mem_gnt/mem_rvalid/mem_rdata in
// Non-memory instructions are held for one cycle and passed on. Loads and
// stores issue one bus access (request held until grant, then wait for the
// response); loads replace the result with the aligned, extended data.
// Optional build macro MEMORY_STAGE_MISALIGN_TRAP_EN adds misaligned_out and
// turns misaligned halfword/word accesses into a fault with no bus access.
module memory_stage
  import pipeline_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  output logic                               stall_prev,
  input  logic                               prev_done,
  input  logic                               next_stall,
  output logic                               done_next,
  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  input  logic                               program_count_valid_in,
  input  op_flags_t                          op_flags_in,
  input  logic [2:0]                         funct3_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  input  logic [DATA_WIDTH-1:0]              store_data_in,
  output logic [ADDR_WIDTH-1:0]              program_count_out,
  output logic                               program_count_valid_out,
  output op_flags_t                          op_flags_out,
  output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
  output logic                               write_register_valid_out,
  output logic [DATA_WIDTH-1:0]              result_data_out,
  output logic                               result_data_valid_out,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [3:0]                         mem_wstrb,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  input  logic                               mem_gnt,
  input  logic                               mem_rvalid,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  ,
  output logic                               misaligned_out
`endif
);

  mem_state_t state, state_next;

  logic transfer_prev;
  logic transfer_next;
  logic is_mem_in;
  logic go_bus;
  logic bus_active;

  logic [ADDR_WIDTH-1:0]              pc_p1;
  logic                               pc_vld_p1;
  op_flags_t                          flags_p1;
  logic [2:0]                         funct3_p1;
  logic [REGISTER_INDEXING_WIDTH-1:0] wr_p1;
  logic                               wr_vld_p1;
  logic [DATA_WIDTH-1:0]              result_p1;
  logic                               result_vld_p1;
  logic [DATA_WIDTH-1:0]              store_p1;

  logic [3:0]            lane_wstrb;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] load_data;

  // Handshake: the stage can take a new instruction only when empty or when
  // the held one leaves in the same cycle.
  assign done_next     = !rst && (state == READY);
  assign transfer_next = done_next && !next_stall;
  assign stall_prev    = rst || ((state != EMPTY) && !transfer_next);
  assign transfer_prev = prev_done && !stall_prev;

  assign is_mem_in = op_flags_in.load || op_flags_in.store;

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  logic misalign_in;
  logic misaligned_p1;

  assign misalign_in = is_mem_in && is_misaligned(funct3_in, result_data_in[1:0]);
  assign go_bus      = is_mem_in && !misalign_in;
`else
  assign go_bus      = is_mem_in;
`endif

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: state_next = EMPTY;
      REQ:   if (mem_gnt) state_next = RESP;
      RESP:  if (mem_rvalid) state_next = READY;
      READY: if (transfer_next) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
    // transfer_prev can only be high in EMPTY or a draining READY.
    if (transfer_prev) begin
      state_next = go_bus ? REQ : READY;
    end
  end

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_p1 <= 1'b0;
    end else if (transfer_prev) begin
      misaligned_p1 <= misalign_in;
    end
  end

  assign misaligned_out = misaligned_p1 && done_next;
`endif

  // Stage p1: instruction bundle held while the access is in flight
  always_ff @(posedge clk) begin
    if (transfer_prev) begin
      pc_p1         <= program_count_in;
      pc_vld_p1     <= program_count_valid_in;
      flags_p1      <= op_flags_in;
      funct3_p1     <= funct3_in;
      wr_p1         <= write_register_in;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
      wr_vld_p1     <= write_register_valid_in && !misalign_in;
`else
      wr_vld_p1     <= write_register_valid_in;
`endif
      result_p1     <= result_data_in;
      result_vld_p1 <= result_data_valid_in;
      store_p1      <= store_data_in;
    end else if ((state == RESP) && mem_rvalid && flags_p1.load) begin
      result_p1     <= load_data;
    end
  end

  mem_lane_align u_align (
    .funct3     (funct3_p1),
    .addr_lo    (result_p1[1:0]),
    .store_data (store_p1),
    .rdata      (mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  // Bus drive: all request fields come from held registers, so they stay
  // stable for as long as the request waits for its grant.
  assign bus_active = !rst && (state == REQ);
  assign mem_req    = bus_active;
  assign mem_we     = bus_active && flags_p1.store;
  assign mem_addr   = {result_p1[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wstrb  = (bus_active && flags_p1.store) ? lane_wstrb : 4'b0000;
  assign mem_wdata  = lane_wdata;

  assign program_count_out        = pc_p1;
  assign program_count_valid_out  = pc_vld_p1;
  assign op_flags_out             = flags_p1;
  assign write_register_out       = wr_p1;
  assign write_register_valid_out = wr_vld_p1;
  assign result_data_out          = result_p1;
  assign result_data_valid_out    = result_vld_p1;

endmodule
